// File: rtl/kbd_scan_4x4.sv
// 4x4 matrix keypad scanner: drives one column low at a time, debounces the
// full key map and reports newly pressed keys through a valid/ack handshake.
module kbd_scan_4x4 #(
  parameter int CLK_DIV  = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rows,
  output logic [3:0]  cols,
  output logic [3:0]  key_code,
  output logic        key_valid,
  input  logic        key_ack,
  output logic        overrun,
  output logic        pressed,
  output logic [15:0] key_map
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE);

  logic [3:0]       rows_meta_r;
  logic [3:0]       rows_sync_r;
  logic [DIV_W-1:0] div_r;
  logic [1:0]       col_r;
  logic [3:0]       cols_r;
  logic [15:0]      raw_r;
  logic [15:0]      prev_raw_r;
  logic [CNT_W-1:0] cnt_r;
  logic [15:0]      key_map_r;
  logic [15:0]      map_old_r;
  logic             pressed_r;
  logic             upd_r;
  logic [3:0]       key_code_r;
  logic             key_valid_r;
  logic             overrun_r;

  logic             tick_s;
  logic             scan_done_s;
  logic [15:0]      raw_next_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic [15:0]      new_keys_s;
  logic             event_s;
  logic [3:0]       event_idx_s;

  // Index of the lowest set bit; callers only use it when v is non-zero.
  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      idx = v[i] ? 4'(i) : idx;
    end
    return idx;
  endfunction

  // Two-flop synchroniser for the asynchronous row lines (idle high).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rows_meta_r <= 4'hF;
      rows_sync_r <= 4'hF;
    end else begin
      rows_meta_r <= rows;
      rows_sync_r <= rows_meta_r;
    end
  end

  // Column-slot divider and active-low column drive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_r  <= {DIV_W{1'b0}};
      col_r  <= 2'd0;
      cols_r <= 4'b1110;
    end else if (tick_s) begin
      div_r  <= {DIV_W{1'b0}};
      col_r  <= col_r + 2'd1;
      cols_r <= ~(4'b0001 << (col_r + 2'd1));
    end else begin
      div_r  <= div_r + DIV_W'(1);
      col_r  <= col_r;
      cols_r <= cols_r;
    end
  end

  // Raw-scan assembly, debounce count and event detection.
  always_comb begin
    tick_s      = (div_r == DIV_LAST);
    scan_done_s = tick_s && (col_r == 2'd3);
    raw_next_s  = raw_r;
    if (tick_s) begin
      raw_next_s[{col_r, 2'b00} +: 4] = ~rows_sync_r;
    end else begin
      raw_next_s = raw_r;
    end
    if (raw_next_s == prev_raw_r) begin
      cnt_next_s = (cnt_r >= CNT_MAX) ? CNT_MAX : cnt_r + CNT_W'(1);
    end else begin
      cnt_next_s = CNT_W'(1);
    end
    new_keys_s  = key_map_r & ~map_old_r;
    event_s     = upd_r && (new_keys_s != 16'h0000);
    event_idx_s = lowest_idx(new_keys_s);
  end

  // Scan capture and debounced key-map update at the end of each full scan.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      raw_r      <= 16'h0000;
      prev_raw_r <= 16'h0000;
      cnt_r      <= {CNT_W{1'b0}};
      key_map_r  <= 16'h0000;
      map_old_r  <= 16'h0000;
      pressed_r  <= 1'b0;
      upd_r      <= 1'b0;
    end else begin
      raw_r <= raw_next_s;
      upd_r <= 1'b0;
      if (scan_done_s) begin
        prev_raw_r <= raw_next_s;
        cnt_r      <= cnt_next_s;
        if (cnt_next_s >= CNT_MAX) begin
          map_old_r <= key_map_r;
          key_map_r <= raw_next_s;
          pressed_r <= |raw_next_s;
          upd_r     <= 1'b1;
        end
      end
    end
  end

  // Consumer handshake; a fresh event outranks a same-cycle acknowledge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_code_r  <= 4'd0;
      key_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else if (event_s) begin
      if (!key_valid_r || key_ack) begin
        key_code_r  <= event_idx_s;
        key_valid_r <= 1'b1;
      end else begin
        overrun_r <= 1'b1;
      end
    end else if (key_ack && key_valid_r) begin
      key_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      key_valid_r <= key_valid_r;
    end
  end

  assign cols      = cols_r;
  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;
  assign overrun   = overrun_r;
  assign pressed   = pressed_r;
  assign key_map   = key_map_r;

endmodule

// File: tb/tb_kbd_scan_4x4.sv
// Self-checking bench for kbd_scan_4x4: directed keypad scenarios followed by
// random key activity, all compared every cycle against a cycle-count model.
module tb_kbd_scan_4x4;
  localparam int CLK_DIV  = 4;
  localparam int DEBOUNCE = 2;
  localparam int SCAN     = 4 * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ack = 1'b0;
  logic        overrun;
  logic        pressed;
  logic [15:0] key_map;
  logic [15:0] keys = 16'h0000;

  int errors = 0;
  int checks = 0;

  // Reference state: time is counted in clock edges since reset release.
  int          m_e;
  logic [3:0]  m_r1, m_r2;
  logic [15:0] m_raw, m_prev, m_map;
  int          m_cnt;
  bit          m_pend;
  int          m_idx;
  logic [3:0]  m_code;
  bit          m_valid, m_over;

  kbd_scan_4x4 #(.CLK_DIV(CLK_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk), .reset(reset), .rows(rows), .cols(cols),
    .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack),
    .overrun(overrun), .pressed(pressed), .key_map(key_map)
  );

  always #5 clk = ~clk;

  // Keypad: a row reads low when any pressed key on it sits in a driven column.
  always_comb begin
    rows = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4+r] && !cols[c]) rows[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_e = 0; m_r1 = 4'hF; m_r2 = 4'hF;
    m_raw = 16'h0; m_prev = 16'h0; m_map = 16'h0; m_cnt = 0;
    m_pend = 0; m_idx = 0; m_code = 4'h0; m_valid = 0; m_over = 0;
  endtask

  task automatic model_step(input logic [3:0] rnow, input logic ack);
    int col;
    logic [15:0] nw;
    if (m_pend) begin
      if (!m_valid) begin m_code = 4'(m_idx); m_valid = 1; end
      else if (ack) m_code = 4'(m_idx);
      else m_over = 1;
    end else if (ack && m_valid) begin
      m_valid = 0; m_over = 0;
    end
    m_pend = 0;
    if (m_e % CLK_DIV == CLK_DIV - 1) begin
      col = (m_e / CLK_DIV) % 4;
      m_raw[col*4 +: 4] = ~m_r2;
      if (col == 3) begin
        if (m_raw == m_prev) m_cnt = (m_cnt + 1 > DEBOUNCE) ? DEBOUNCE : m_cnt + 1;
        else m_cnt = 1;
        m_prev = m_raw;
        if (m_cnt >= DEBOUNCE) begin
          nw = m_raw & ~m_map;
          m_map = m_raw;
          for (int i = 15; i >= 0; i--)
            if (nw[i]) begin m_pend = 1; m_idx = i; end
        end
      end
    end
    m_r2 = m_r1;
    m_r1 = rnow;
    m_e++;
  endtask

  task automatic check_all();
    logic [3:0] one;
    logic [3:0] exp_cols;
    one = 4'b0001;
    exp_cols = ~(one << ((m_e / CLK_DIV) % 4));
    check("cols", {12'h0, cols}, {12'h0, exp_cols});
    check("key_code", {12'h0, key_code}, {12'h0, m_code});
    check("key_valid", {15'h0, key_valid}, {15'h0, m_valid});
    check("overrun", {15'h0, overrun}, {15'h0, m_over});
    check("pressed", {15'h0, pressed}, {15'h0, |m_map});
    check("key_map", key_map, m_map);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_step(rows, key_ack);
    else model_reset();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic align();
    int guard;
    guard = 0;
    while (m_e % SCAN != 0 && guard < SCAN) begin tick(); guard++; end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!key_valid && n < 200) begin tick(); n++; end
    check("wait_valid", {15'h0, key_valid}, 16'h0001);
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
    check("ack_clears", {15'h0, key_valid}, 16'h0000);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cols"}, {12'h0, cols}, 16'h000E);
    check({tag, "_code"}, {12'h0, key_code}, 16'h0000);
    check({tag, "_valid"}, {15'h0, key_valid}, 16'h0000);
    check({tag, "_ovr"}, {15'h0, overrun}, 16'h0000);
    check({tag, "_pressed"}, {15'h0, pressed}, 16'h0000);
    check({tag, "_map"}, key_map, 16'h0000);
  endtask

  initial begin
    int n;
    int hold;
    model_reset();
    #1 reset = 1'b0;
    #1 check_reset_outputs("por");
    run(2);
    reset = 1'b1;

    // Idle scanning: columns rotate, nothing else moves.
    run(3 * SCAN);

    // Single held key, exact press latency, then acknowledge.
    align();
    keys = 16'h0040;
    wait_valid(n);
    check("lat_press", 16'(n), 16'd33);
    check("t2_code", {12'h0, key_code}, 16'h0006);
    check("t2_map", key_map, 16'h0040);
    check("t2_pressed", {15'h0, pressed}, 16'h0001);
    ack_pulse();
    check("t2_map_kept", key_map, 16'h0040);
    keys = 16'h0000;
    run(3 * SCAN);

    // Bouncing key is rejected, then accepted once steady.
    align();
    for (int i = 0; i < 4 * SCAN; i++) begin
      keys = ((i / 3) % 2 == 0) ? 16'h1000 : 16'h0000;
      tick();
    end
    check("t3_bounce_valid", {15'h0, key_valid}, 16'h0000);
    check("t3_bounce_map", key_map, 16'h0000);
    keys = 16'h1000;
    wait_valid(n);
    check("t3_code", {12'h0, key_code}, 16'h000C);
    ack_pulse();
    keys = 16'h0000;
    run(3 * SCAN);

    // Second press while the first is unacknowledged sets overrun.
    keys = 16'h0040;
    wait_valid(n);
    check("t4_code", {12'h0, key_code}, 16'h0006);
    keys = 16'h0240;
    n = 0;
    while (!overrun && n < 200) begin tick(); n++; end
    check("t4_overrun", {15'h0, overrun}, 16'h0001);
    check("t4_code_held", {12'h0, key_code}, 16'h0006);
    ack_pulse();
    check("t4_ovr_clr", {15'h0, overrun}, 16'h0000);
    keys = 16'h0000;
    run(4 * SCAN);
    check("t4_release_valid", {15'h0, key_valid}, 16'h0000);
    check("t4_release_map", key_map, 16'h0000);

    // Two keys in one scan: lowest index wins, no overrun.
    align();
    keys = 16'h0208;
    wait_valid(n);
    check("t5_code", {12'h0, key_code}, 16'h0003);
    check("t5_ovr", {15'h0, overrun}, 16'h0000);
    check("t5_map", key_map, 16'h0208);
    ack_pulse();
    keys = 16'h0000;
    run(3 * SCAN);

    // Asynchronous reset mid-scan, then re-report of a held key.
    keys = 16'h0020;
    wait_valid(n);
    run(5);
    #2 reset = 1'b0;
    #1 check_reset_outputs("async");
    model_reset();
    run(2);
    reset = 1'b1;
    wait_valid(n);
    check("lat_rereport", 16'(n), 16'd33);
    check("t6_code", {12'h0, key_code}, 16'h0005);
    ack_pulse();
    keys = 16'h0000;

    // Random key activity with random acknowledges.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        keys = 16'h0000;
        for (int k = $urandom_range(0, 2); k > 0; k--)
          keys[$urandom_range(0, 15)] = 1'b1;
        hold = $urandom_range(10, 120);
      end
      hold--;
      key_ack = ($urandom_range(0, 15) == 0);
      tick();
    end
    key_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kbd_scan_4x4.md
Name: kbd_scan_4x4

Overview:
- Scanning input driver for a 4x4 matrix keypad; the input-side counterpart of the multiplexed 7-segment display drivers.
- Drives one column low at a time and samples the four row lines.
- Debounces the full 16-key map and reports newly pressed keys as 4-bit codes through a valid/ack handshake.
- Sits between keypad pins and a CPU-visible peripheral register.

Parameters:
CLK_DIV, 50000, clk cycles per column slot; must be >= 4
DEBOUNCE, 4, consecutive identical full scans required before the key map updates; must be >= 1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous reset, active-low
rows  input  4  keypad row lines, active-low (pulled up externally), asynchronous to clk
cols  output  4  keypad column drives, active-low, exactly one bit low
key_code  output  4  code of the last reported key: col*4+row
key_valid  output  1  key_code holds an unacknowledged press
key_ack  input  1  single-cycle acknowledge from the consumer
overrun  output  1  sticky: a press was lost while key_valid=1
pressed  output  1  at least one key in the debounced map
key_map  output  16  debounced key state; bit col*4+row = 1 when pressed

Behaviour:
- Reset (reset=0, asynchronous):
  - cols=4'b1110 (column 0 active); key_code=0, key_valid=0, overrun=0, key_map=0, pressed=0.
  - Divider, column index, raw/previous-scan vectors and debounce count all clear to 0.
  - Reset mid-scan aborts the scan; no partial result is kept.
- Synchroniser: rows pass through a 2-flop synchroniser before any use.
- Tick generation:
  - Divider counts 0..CLK_DIV-1; tick is the cycle where the divider = CLK_DIV-1.
  - On tick, the synchronised rows are sampled into raw[col*4 +: 4] as ~rows_sync.
  - Then col increments mod 4 and cols = ~(1<<col).
  - A column is therefore driven for CLK_DIV cycles before it is sampled.
- Scan completion: the tick that samples column 3 completes a scan. On that cycle:
  - If the new raw equals prev_raw: cnt = min(cnt+1, DEBOUNCE). Otherwise cnt = 1.
  - prev_raw = raw.
  - If the updated cnt >= DEBOUNCE: key_map = raw.
- Press event, evaluated the cycle after a key_map update:
  - new = key_map_new & ~key_map_old.
  - If new != 0, the lowest set index is the event. Other keys newly set in the same update are dropped, with no overrun.
- Handshake, priority in this order each cycle:
  - Event and key_valid=0: key_code = index, key_valid = 1.
  - Event, key_valid=1, key_ack=1 in the same cycle: key_code = index, key_valid stays 1, overrun is not set.
  - Event, key_valid=1, key_ack=0: key_code is held, overrun = 1.
  - No event and key_ack=1: key_valid = 0, overrun = 0.
  - key_ack while key_valid=0: no effect.
- Releases: update key_map and pressed; they never generate events.
- pressed = |key_map, registered together with key_map.
- Latency: a key held steadily from before a scan starts sets key_map at the end of the DEBOUNCE-th scan containing it. key_valid rises 1 cycle later. Scan period = 4*CLK_DIV cycles.

Test Plan:
Bench keypad model: rows[r]=0 iff key(c,r) is pressed and cols[c]=0. Parameters CLK_DIV=4, DEBOUNCE=2.
1. Reset, then release -> cols=1110,1101,1011,0111 repeating, 4 cycles each; all other outputs 0 throughout.
2. Hold key row2/col1 from a scan boundary -> after the second complete scan, key_map=16'h0040 and pressed=1; one cycle later key_valid=1, key_code=4'h6. Pulse key_ack -> key_valid=0 next cycle; key_map stays 16'h0040.
3. Key row0/col3 toggling every 3 cycles for 4 scans -> key_valid stays 0 and key_map=0. Then hold it steady -> key_code=4'hC after 2 stable scans.
4. Key 6 valid and unacked; press key 9 -> key_code stays 6, overrun=1. key_ack -> key_valid=0, overrun=0. Releasing both keys gives no event; key_map returns to 0.
5. Keys 3 and 9 pressed in the same scan -> key_code=3, overrun=0, key_map=16'h0208.
6. Assert reset mid-scan with key_valid=1 -> all outputs take reset values immediately, without a clock edge. After release, a still-held key is re-reported after 2 scans.
